// File: rtl/restador_serial_pkg.sv
// Shared state encoding and sizing helper for the bit-serial subtractor.
package restador_serial_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    RESTANDO = 2'd1,
    FIN      = 2'd2
  } estado_t;

  // Bit counter width; at least one bit so N=1 still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/restador_completo.sv
// Full subtractor built from two cascaded half subtractors; purely combinational.
module restador_completo (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  assign d1 = x ^ y;
  assign b1 = ~x & y;
  assign d  = d1 ^ bi;
  assign b2 = ~d1 & bi;
  assign bo = b1 | b2;

endmodule

// File: rtl/restador_serial.sv
// Bit-serial N-bit subtractor R = A - B, LSB first, one bit per clock.
// Result lands N edges after inicio is accepted; inicio is ignored while ocupado.
module restador_serial
  import restador_serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] R,
  output logic         AN,
  output logic         ocupado,
  output logic         valido
);

  localparam int CW = cnt_width(N);

  estado_t        estado;
  estado_t        estado_sig;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   sr;
  logic [N-1:0]   sr_sig;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic           d;
  logic           bo;
  logic           ultimo;

  restador_completo u_celda (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  assign ultimo = (cnt == CW'(N - 1));

  // New difference bit enters at the MSB so the LSB ends up at bit 0 after N shifts.
  always_comb begin
    sr_sig        = sr >> 1;
    sr_sig[N-1]   = d;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:   if (inicio) estado_sig = RESTANDO;
      RESTANDO: if (ultimo) estado_sig = FIN;
      FIN:      estado_sig = REPOSO;
      default:  estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      R      <= '0;
      AN     <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            sa     <= A;
            sb     <= B;
            sr     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RESTANDO: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sr     <= sr_sig;
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          if (ultimo) begin
            R  <= sr_sig;
            AN <= bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign ocupado = (estado != REPOSO);
  assign valido  = (estado == FIN);

endmodule
